seq_detector_param: RTL and testbench

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_detector_param.sv | 89 ++++++++
 tb/tb_seq_detector_param.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param - serial pattern detector with runtime pattern load,
// overlap control, prefix-length tracking and a saturating match counter.
module seq_detector_param #(
  parameter int                PAT_W       = 5,
  parameter logic [PAT_W-1:0]  DEF_PATTERN = 5'b10110,
  parameter int                CNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_data,
  input  logic                       in_valid,
  input  logic                       overlap_en,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic                       cnt_clr,
  output logic                       sq_detected,
  output logic [$clog2(PAT_W+1)-1:0] match_len,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int               LW      = $clog2(PAT_W + 1);
  localparam logic [LW-1:0]    FULL    = LW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] hist;
  logic [LW-1:0]    fill;

  logic [PAT_W-1:0] sh;
  logic [LW-1:0]    fn;
  logic             hit;
  logic [PAT_W-1:0] hist_n;
  logic [LW-1:0]    fill_n;
  logic [LW-1:0]    len_n;
  logic [PAT_W-1:0] mask;
  logic [CNT_W-1:0] cnt_n;

  always_comb begin
    sh     = {hist[PAT_W-2:0], in_data};
    fn     = (fill == FULL) ? FULL : fill + 1'b1;
    hit    = in_valid && !cfg_load && (fn == FULL) && (sh == pat);
    hist_n = hist;
    fill_n = fill;
    if (cfg_load) begin
      hist_n = '0;
      fill_n = '0;
    end else if (in_valid) begin
      hist_n = sh;
      fill_n = (hit && !overlap_en) ? '0 : fn;
    end

    // Longest pattern prefix that ends the post-update history; the loop
    // runs upward so the last qualifying k wins.
    len_n = '0;
    mask  = '0;
    for (int k = 1; k <= PAT_W; k++) begin
      mask = PAT_W'((1 << k) - 1);
      if ((LW'(k) <= fill_n) && ((hist_n & mask) == (pat >> (PAT_W - k))))
        len_n = LW'(k);
    end

    cnt_n = match_cnt;
    if (cnt_clr)
      cnt_n = '0;
    if (hit)
      cnt_n = cnt_clr ? CNT_W'(1) :
              (match_cnt == CNT_MAX) ? match_cnt : match_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat         <= DEF_PATTERN;
      hist        <= '0;
      fill        <= '0;
      sq_detected <= 1'b0;
      match_len   <= '0;
      match_cnt   <= '0;
    end else begin
      if (cfg_load)
        pat <= cfg_pattern;
      hist        <= hist_n;
      fill        <= fill_n;
      sq_detected <= hit;
      match_len   <= len_n;
      match_cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed table-driven bench for seq_detector_param.
module tb_seq_detector_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, in_data, in_valid, overlap_en, cfg_load, cnt_clr;
  logic [4:0] cfg_pattern;
  logic       sq_detected;
  logic [2:0] match_len;
  logic [7:0] match_cnt;

  logic       reset2, in_data2, in_valid2, cnt_clr2;
  logic       sq_detected2;
  logic [2:0] match_len2;
  logic [1:0] match_cnt2;

  int checks   = 0;
  int failures = 0;

  seq_detector_param dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .overlap_en(overlap_en), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cnt_clr(cnt_clr), .sq_detected(sq_detected), .match_len(match_len),
    .match_cnt(match_cnt)
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset2), .in_data(in_data2), .in_valid(in_valid2),
    .overlap_en(1'b0), .cfg_load(1'b0), .cfg_pattern(5'b00000),
    .cnt_clr(cnt_clr2), .sq_detected(sq_detected2), .match_len(match_len2),
    .match_cnt(match_cnt2)
  );

  typedef struct {
    logic       rst, vld, dat, ovl, ld;
    logic [4:0] cp;
    logic       clr;
    logic       det;
    logic [2:0] len;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst, logic vld, logic dat, logic ovl, logic ld,
                              logic [4:0] cp, logic clr, logic det, logic [2:0] len,
                              logic [7:0] cnt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.dat = dat; v.ovl = ovl; v.ld = ld;
    v.cp = cp; v.clr = clr; v.det = det; v.len = len; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  // Shorthand: a consumed bit with no reset, load or clear.
  function automatic void bit_in(logic dat, logic ovl, logic det, logic [2:0] len,
                                 logic [7:0] cnt);
    add(1'b0, 1'b1, dat, ovl, 1'b0, 5'b0, 1'b0, det, len, cnt);
  endfunction

  task automatic chk(string nm, int idx, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic step2(logic vld, logic dat, logic clr);
    @(negedge clk);
    in_valid2 = vld; in_data2 = dat; cnt_clr2 = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Overlapping stream 1,0,1,1,0,1,1,0
    add(1, 0, 0, 1, 0, 5'b0, 0, 0, 0, 0);
    bit_in(1, 1, 0, 1, 0); bit_in(0, 1, 0, 2, 0); bit_in(1, 1, 0, 3, 0);
    bit_in(1, 1, 0, 4, 0); bit_in(0, 1, 1, 5, 1); bit_in(1, 1, 0, 3, 1);
    bit_in(1, 1, 0, 4, 1); bit_in(0, 1, 1, 5, 2);
    // Same stream, non-overlapping
    add(1, 0, 0, 0, 0, 5'b0, 0, 0, 0, 0);
    bit_in(1, 0, 0, 1, 0); bit_in(0, 0, 0, 2, 0); bit_in(1, 0, 0, 3, 0);
    bit_in(1, 0, 0, 4, 0); bit_in(0, 0, 1, 0, 1); bit_in(1, 0, 0, 1, 1);
    bit_in(1, 0, 0, 1, 1); bit_in(0, 0, 0, 2, 1);
    // Valid gap mid-pattern: state holds
    add(1, 0, 0, 1, 0, 5'b0, 0, 0, 0, 0);
    bit_in(1, 1, 0, 1, 0); bit_in(0, 1, 0, 2, 0); bit_in(1, 1, 0, 3, 0);
    add(0, 0, 1, 1, 0, 5'b0, 0, 0, 3, 0);
    add(0, 0, 0, 1, 0, 5'b0, 0, 0, 3, 0);
    add(0, 0, 1, 1, 0, 5'b0, 0, 0, 3, 0);
    bit_in(1, 1, 0, 4, 0); bit_in(0, 1, 1, 5, 1);
    // Pattern reload after partial history; counter kept
    bit_in(1, 1, 0, 3, 1); bit_in(0, 1, 0, 2, 1); bit_in(1, 1, 0, 3, 1);
    add(0, 1, 1, 1, 1, 5'b11100, 0, 0, 0, 1);
    bit_in(1, 1, 0, 1, 1); bit_in(1, 1, 0, 2, 1); bit_in(1, 1, 0, 3, 1);
    bit_in(0, 1, 0, 4, 1); bit_in(0, 1, 1, 5, 2);
    // Mid-pattern reset beats cfg_load and valid data
    add(1, 0, 0, 1, 0, 5'b0, 0, 0, 0, 0);
    bit_in(1, 1, 0, 1, 0); bit_in(0, 1, 0, 2, 0); bit_in(1, 1, 0, 3, 0);
    bit_in(1, 1, 0, 4, 0);
    add(1, 1, 0, 1, 1, 5'b11100, 0, 0, 0, 0);
    bit_in(0, 1, 0, 0, 0);
    bit_in(1, 1, 0, 1, 0); bit_in(0, 1, 0, 2, 0); bit_in(1, 1, 0, 3, 0);
    bit_in(1, 1, 0, 4, 0); bit_in(0, 1, 1, 5, 1);
    // Clear alone, no consumed bit
    add(0, 0, 0, 1, 0, 5'b0, 1, 0, 5, 0);

    reset = 1; in_data = 0; in_valid = 0; overlap_en = 1; cfg_load = 0;
    cfg_pattern = '0; cnt_clr = 0;
    reset2 = 1; in_data2 = 0; in_valid2 = 0; cnt_clr2 = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; in_valid = vecs[i].vld; in_data = vecs[i].dat;
      overlap_en = vecs[i].ovl; cfg_load = vecs[i].ld;
      cfg_pattern = vecs[i].cp; cnt_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      chk("sq_detected", i, {7'b0, sq_detected}, {7'b0, vecs[i].det});
      chk("match_len", i, {5'b0, match_len}, {5'b0, vecs[i].len});
      chk("match_cnt", i, match_cnt, vecs[i].cnt);
    end

    // CNT_W=2: saturation over five separated matches, then clear with match
    @(negedge clk);
    reset2 = 0;
    chk("cnt2_reset", 0, {6'b0, match_cnt2}, 8'd0);
    for (int m = 0; m < 5; m++) begin
      step2(1, 1, 0); step2(1, 0, 0); step2(1, 1, 0); step2(1, 1, 0);
      step2(1, 0, 0);
      chk("det2", m, {7'b0, sq_detected2}, 8'd1);
      chk("cnt2_sat", m, {6'b0, match_cnt2}, (m < 3) ? 8'(m + 1) : 8'd3);
      step2(0, 0, 0);
      chk("det2_gap", m, {7'b0, sq_detected2}, 8'd0);
    end
    step2(1, 1, 0); step2(1, 0, 0); step2(1, 1, 0); step2(1, 1, 0);
    chk("len2_prefix", 0, {5'b0, match_len2}, 8'd4);
    step2(1, 0, 1);
    chk("det2_clr", 0, {7'b0, sq_detected2}, 8'd1);
    chk("cnt2_clr_match", 0, {6'b0, match_cnt2}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
